// File: rtl/ahb_lcd_8080.sv
// ahb_lcd_8080: AHB-Lite slave feeding an 8080 LCD through a write FIFO and a WR-strobe engine
module ahb_lcd_8080 #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TLOW_RST   = 2,
    parameter int THIGH_RST  = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic                  LCD_CS,
    output logic                  LCD_RST,
    output logic                  LCD_BL_CTR,
    output logic                  LCD_RS,
    output logic                  LCD_WR,
    output logic                  LCD_RD,
    output logic [DATA_WIDTH-1:0] LCD_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WR_LOW, WR_HIGH} state_t;

    logic                wr_r;
    logic [5:0]          addr_r;
    logic [2:0]          ctrl;
    logic [15:0]         timing;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW:0]         wp, rp, level;
    logic                full, empty, busy, push_req, push, pop, stall, wr_n;
    state_t              state, state_n;
    logic [7:0]          cnt, cnt_n, tlow, thigh;
    logic                unused;

    assign unused    = ^{HADDR[31:8], HADDR[1:0], HTRANS[0], HSIZE, HPROT, HWDATA[31:16]};
    assign level     = wp - rp;
    assign full      = level == (AW+1)'(FIFO_DEPTH);
    assign empty     = wp == rp;
    assign busy      = !empty || state != IDLE;
    assign push_req  = wr_r && (addr_r == 6'd1 || addr_r == 6'd2);
    assign stall     = push_req && full && !pop;
    assign push      = push_req && !stall;
    assign HREADYOUT = !stall;
    assign HRESP     = 1'b0;
    assign LCD_RD    = 1'b1;
    assign LCD_CS    = ctrl[0];
    assign LCD_RST   = ctrl[1];
    assign LCD_BL_CTR = ctrl[2];
    assign tlow      = (timing[7:0] == 8'd0) ? 8'd1 : timing[7:0];
    assign thigh     = (timing[15:8] == 8'd0) ? 8'd1 : timing[15:8];
    assign HRDATA    = (addr_r == 6'd0) ? {29'd0, ctrl} :
                       (addr_r == 6'd3) ? {16'd0, timing} :
                       (addr_r == 6'd4) ? {16'd0, 8'(level), 5'd0, empty, full, busy} : 32'd0;

    // address phase capture; held while the bus is stalled
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_r   <= 1'b0;
            addr_r <= 6'd0;
        end else if (HREADY) begin
            wr_r   <= HSEL && HTRANS[1] && HWRITE;
            addr_r <= HADDR[7:2];
        end
    end

    // CTRL and TIMING registers written in the data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl   <= 3'b001;
            timing <= {8'(THIGH_RST), 8'(TLOW_RST)};
        end else begin
            if (wr_r && addr_r == 6'd0) ctrl <= HWDATA[2:0];
            if (wr_r && addr_r == 6'd3) timing <= HWDATA[15:0];
        end
    end

    // FIFO pointers, one extra bit to tell full from empty
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(push);
            rp <= rp + (AW+1)'(pop);
        end
    end

    // FIFO storage, entry = {rs, data}; address bit 1 distinguishes DATA from CMD
    always_ff @(posedge HCLK) begin
        if (push) mem[wp[AW-1:0]] <= {addr_r[1], HWDATA[DATA_WIDTH-1:0]};
    end

    // strobe engine registers; panel bus loads only on a pop so it stays stable for the whole beat
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            LCD_WR   <= 1'b1;
            LCD_RS   <= 1'b0;
            LCD_DATA <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            LCD_WR <= wr_n;
            if (pop) {LCD_RS, LCD_DATA} <= mem[rp[AW-1:0]];
        end
    end

    // next state: counts are loaded from TIMING only on entry to each phase
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = LCD_WR;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = WR_LOW;
                    cnt_n   = tlow;
                    wr_n    = 1'b0;
                end
            end
            WR_LOW: begin
                if (cnt == 8'd1) begin
                    state_n = WR_HIGH;
                    cnt_n   = thigh;
                    wr_n    = 1'b1;
                end else cnt_n = cnt - 8'd1;
            end
            WR_HIGH: begin
                if (cnt == 8'd1) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = WR_LOW;
                        cnt_n   = tlow;
                        wr_n    = 1'b0;
                    end else state_n = IDLE;
                end else cnt_n = cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ahb_lcd_8080.sv
// tb_ahb_lcd_8080: directed bench for the AHB 8080 LCD write engine
module tb_ahb_lcd_8080;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [3:0]  HPROT = 4'b0011;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        LCD_CS, LCD_RST, LCD_BL_CTR, LCD_RS, LCD_WR, LCD_RD;
    logic [15:0] LCD_DATA;

    int total = 0;
    int bad = 0;

    logic [16:0] beats[$];
    int          lows[$];
    int          highs[$];
    int          run = 0;
    logic        prev = 1'b1;
    int          bb, bl, bh;
    logic [31:0] bd [16];
    logic        st [16];
    logic [31:0] r;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_lcd_8080 dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .LCD_CS(LCD_CS),
        .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR),
        .LCD_RD(LCD_RD), .LCD_DATA(LCD_DATA)
    );

    // panel-side monitor: run lengths of each WR level and the word latched on each rising edge
    always @(negedge HCLK) begin
        if (LCD_WR !== prev) begin
            if (LCD_WR) begin
                lows.push_back(run);
                beats.push_back({LCD_RS, LCD_DATA});
            end else highs.push_back(run);
            run <= 1;
        end else run <= run + 1;
        prev <= LCD_WR;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int w;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'd0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        w = 0;
        while (!HREADYOUT && w < 200) begin @(posedge HCLK); #1; w++; end
        if (w >= 200) check("wr_timeout", 32'(w), 32'd0);
        @(posedge HCLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'd0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic burst(input logic [7:0] a, input int n);
        int w;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'd0, a};
        @(posedge HCLK); #1;
        for (int i = 0; i < n; i++) begin
            HWDATA = bd[i];
            if (i == n - 1) begin HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; end
            st[i] = 1'b0;
            w = 0;
            while (!HREADYOUT && w < 200) begin st[i] = 1'b1; @(posedge HCLK); #1; w++; end
            if (w >= 200) check("burst_timeout", 32'(w), 32'd0);
            @(posedge HCLK); #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        s = 32'd1;
        n = 0;
        while (s[0] && n < 300) begin rd(8'h10, s); n++; end
        check({tag, "_idle"}, {31'd0, s[0]}, 32'd0);
    endtask

    task automatic mark();
        bb = beats.size(); bl = lows.size(); bh = highs.size();
    endtask

    function automatic logic [31:0] gb(input int i);
        return (bb + i < beats.size()) ? 32'(beats[bb + i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] gl(input int i);
        return (bl + i < lows.size()) ? 32'(lows[bl + i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] gh(input int i);
        return (bh + i < highs.size()) ? 32'(highs[bh + i]) : 32'hDEADBEEF;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then an async reset in the middle of a low phase
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(posedge HCLK); #1;
        check("rst_wr", {31'd0, LCD_WR}, 32'd1);
        check("rst_cs", {31'd0, LCD_CS}, 32'd1);
        check("rst_lcdrst", {31'd0, LCD_RST}, 32'd0);
        check("rst_bl", {31'd0, LCD_BL_CTR}, 32'd0);
        check("rst_rs", {31'd0, LCD_RS}, 32'd0);
        check("rst_data", {16'd0, LCD_DATA}, 32'd0);
        check("rst_hready", {31'd0, HREADYOUT}, 32'd1);
        rd(8'h00, r); check("rst_ctrl", r, 32'h1);
        rd(8'h10, r); check("rst_status", r, 32'h4);
        rd(8'h0C, r); check("rst_timing", r, 32'h0202);
        wr(8'h0C, 32'h0505);
        wr(8'h04, 32'h0055);
        @(posedge HCLK); #1;
        check("mid_low_wr", {31'd0, LCD_WR}, 32'd0);
        #2 HRESET = 1'b1;
        #1;
        check("async_rst_wr", {31'd0, LCD_WR}, 32'd1);
        check("async_rst_data", {16'd0, LCD_DATA}, 32'd0);
        #3 HRESET = 1'b0;
        @(posedge HCLK); #1;
        rd(8'h10, r); check("rst2_status", r, 32'h4);
        rd(8'h0C, r); check("rst2_timing", r, 32'h0202);
        rd(8'h00, r); check("rst2_ctrl", r, 32'h1);

        // 2: single command, 2 low / 3 high, two-edge latency from the address phase
        wr(8'h0C, 32'h0302);
        mark();
        wr(8'h04, 32'h002C);
        @(posedge HCLK); #1;
        check("cmd_wr_e3", {31'd0, LCD_WR}, 32'd0);
        check("cmd_rs", {31'd0, LCD_RS}, 32'd0);
        check("cmd_data", {16'd0, LCD_DATA}, 32'h002C);
        @(posedge HCLK); #1;
        check("cmd_wr_e4", {31'd0, LCD_WR}, 32'd0);
        @(posedge HCLK); #1;
        check("cmd_wr_e5", {31'd0, LCD_WR}, 32'd1);
        @(posedge HCLK); #1;
        check("cmd_wr_e6", {31'd0, LCD_WR}, 32'd1);
        check("cmd_data_hold", {16'd0, LCD_DATA}, 32'h002C);
        rd(8'h10, r); check("cmd_status_high", r, 32'h5);
        rd(8'h10, r); check("cmd_status_idle", r, 32'h4);
        check("cmd_beat", gb(0), 32'h0002C);
        check("cmd_low", gl(0), 32'd2);

        // 3: eight data writes at the default 2/2 timing, gapless
        wr(8'h0C, 32'h0202);
        for (int i = 0; i < 8; i++) bd[i] = 32'h1111 * (i + 1);
        mark();
        burst(8'h08, 8);
        wait_idle("burst8");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b8_beat%0d", i), gb(i), {15'd0, 1'b1, 16'h1111 * 16'(i + 1)});
            check($sformatf("b8_low%0d", i), gl(i), 32'd2);
            if (i > 0) check($sformatf("b8_high%0d", i), gh(i), 32'd2);
        end

        // 4: FIFO overflow attempt behind a long command beat; last three writes stall
        wr(8'h0C, 32'h0808);
        for (int i = 0; i < 11; i++) bd[i] = 32'h0A00 + i;
        mark();
        wr(8'h04, 32'h00AA);
        burst(8'h08, 11);
        rd(8'h10, r); check("ovf_status_full", r, 32'h0803);
        for (int i = 0; i < 11; i++)
            check($sformatf("ovf_stall%0d", i), {31'd0, st[i]}, {31'd0, i >= 8});
        wait_idle("ovf");
        check("ovf_beat_cmd", gb(0), 32'h000AA);
        for (int i = 0; i < 11; i++)
            check($sformatf("ovf_beat%0d", i), gb(i + 1), 32'h10A00 + i);
        check("ovf_low", gl(5), 32'd8);
        check("ovf_high", gh(5), 32'd8);

        // 5: TIMING rewritten during the high phase of a 5/5 beat
        wr(8'h0C, 32'h0505);
        mark();
        wr(8'h08, 32'h5555);
        wr(8'h08, 32'h6666);
        wr(8'h08, 32'h7777);
        repeat (2) @(posedge HCLK);
        #1 wr(8'h0C, 32'h0101);
        wait_idle("tchg");
        check("tchg_low0", gl(0), 32'd5);
        check("tchg_high1", gh(1), 32'd5);
        check("tchg_low1", gl(1), 32'd1);
        check("tchg_high2", gh(2), 32'd1);
        check("tchg_low2", gl(2), 32'd1);
        check("tchg_beat0", gb(0), 32'h15555);
        check("tchg_beat2", gb(2), 32'h17777);

        // 6: zero timing behaves as 1/1, CTRL pins, write-only and unmapped reads
        wr(8'h0C, 32'h0000);
        bd[0] = 32'h0123; bd[1] = 32'hFFFF0456;
        mark();
        burst(8'h08, 2);
        wait_idle("zero");
        check("zero_low0", gl(0), 32'd1);
        check("zero_high1", gh(1), 32'd1);
        check("zero_low1", gl(1), 32'd1);
        check("zero_beat0", gb(0), 32'h10123);
        check("zero_beat1", gb(1), 32'h10456);
        wr(8'h00, 32'h6);
        check("ctrl_cs", {31'd0, LCD_CS}, 32'd0);
        check("ctrl_rst", {31'd0, LCD_RST}, 32'd1);
        check("ctrl_bl", {31'd0, LCD_BL_CTR}, 32'd1);
        rd(8'h00, r); check("ctrl_read", r, 32'h6);
        rd(8'h04, r); check("cmd_read", r, 32'h0);
        rd(8'h08, r); check("data_read", r, 32'h0);
        rd(8'h14, r); check("other_read", r, 32'h0);
        rd(8'h0C, r); check("timing_read", r, 32'h0);
        check("lcd_rd", {31'd0, LCD_RD}, 32'd1);
        check("hresp", {31'd0, HRESP}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
